// File: rtl/seek_controller.sv
// rtl/seek_controller.sv - playback transport and seek controller driving the elapsed-time timer
// Optional feature macro: SEEK_ACCEL_EN (auto-repeat step acceleration).
module seek_debounce #(
    parameter int DEBOUNCE_CYC = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_level
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_armed;
    logic [1:0]    r_live;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_armed <= 1'b0;
            r_live  <= 2'd0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == C_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            // A button held through reset stays masked until it has been seen released.
            if (!r_live[1]) begin
                r_live <= r_live + 2'd1;
            end else if (!r_sync2 && !r_level) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign o_level = r_level & r_armed;
endmodule

module seek_controller #(
    parameter int TICK_DIV     = 50_000_000,
    parameter int DEBOUNCE_CYC = 500_000,
    parameter int HOLD_TICKS   = 2,
    parameter int STEP         = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_btn_play,
    input  logic       i_btn_fwd,
    input  logic       i_btn_back,
    input  logic [8:0] i_position,
    input  logic [8:0] i_song_len,
    output logic       o_count,
    output logic       o_tick,
    output logic [8:0] o_seek_step,
    output logic       o_seek_valid,
    output logic       o_timer_clr,
    output logic       o_at_end
);
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TICK_DIV - 1);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [HW-1:0] H_MAX  = HW'(HOLD_TICKS);
    localparam logic [9:0] STEP1 = 10'(STEP);
`ifdef SEEK_ACCEL_EN
    localparam logic [9:0] STEP2 = 10'(2 * STEP);
    localparam logic [9:0] STEP4 = (4 * STEP > 255) ? 10'd255 : 10'(4 * STEP);
`endif

    typedef enum logic [1:0] {ST_STOP, ST_PLAY, ST_PAUSE, ST_END} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          w_clr_next;
    logic          r_timer_clr;
    logic          r_tick;
    logic [TW-1:0] r_tick_cnt;
    logic [HW-1:0] r_hold_cnt;
    logic          r_seek_valid;
    logic [8:0]    r_seek_step;
    logic          r_play_d;
    logic          r_fwd_d;
    logic          r_back_d;

    logic       w_play_lvl;
    logic       w_fwd_lvl;
    logic       w_back_lvl;
    logic       w_play_press;
    logic       w_fwd_press;
    logic       w_back_press;
    logic       w_past_end;
    logic       w_last_sec;
    logic       w_enter_play;
    logic       w_tick_now;
    logic       w_fwd_only;
    logic       w_back_only;
    logic       w_hold_any;
    logic       w_seek_ok;
    logic       w_repeat;
    logic       w_fire_fwd;
    logic       w_fire_back;
    logic       w_fire;
    logic [9:0] w_pos10;
    logic [9:0] w_len10;
    logic [9:0] w_room;
    logic [9:0] w_base;
    logic [9:0] w_fwd_mag;
    logic [9:0] w_back_mag;
    logic [9:0] w_mag;

    seek_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_play (
        .clk(clk), .reset(reset), .i_btn(i_btn_play), .o_level(w_play_lvl));
    seek_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_fwd (
        .clk(clk), .reset(reset), .i_btn(i_btn_fwd), .o_level(w_fwd_lvl));
    seek_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_back (
        .clk(clk), .reset(reset), .i_btn(i_btn_back), .o_level(w_back_lvl));

    assign w_play_press = w_play_lvl & ~r_play_d;
    assign w_fwd_press  = w_fwd_lvl & ~r_fwd_d;
    assign w_back_press = w_back_lvl & ~r_back_d;

    assign w_pos10    = {1'b0, i_position};
    assign w_len10    = {1'b0, i_song_len};
    assign w_past_end = (w_pos10 >= w_len10);
    assign w_last_sec = ((w_pos10 + 10'd1) >= w_len10);

    always_comb begin
        w_state_next = r_state;
        w_clr_next   = 1'b0;
        if (i_song_len == 9'd0) begin
            w_state_next = ST_STOP;
        end else begin
            case (r_state)
                ST_STOP, ST_END: begin
                    if (w_play_press) begin
                        w_state_next = ST_PLAY;
                        w_clr_next   = 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (w_past_end || (r_tick && w_last_sec)) w_state_next = ST_END;
                    else if (w_play_press)                    w_state_next = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (w_past_end)        w_state_next = ST_END;
                    else if (w_play_press) w_state_next = ST_PLAY;
                end
                default: w_state_next = ST_STOP;
            endcase
        end
    end

    assign w_enter_play = (w_state_next == ST_PLAY) && (r_state != ST_PLAY);
    assign w_tick_now   = (r_state == ST_PLAY) && (w_state_next == ST_PLAY) && (r_tick_cnt == T_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_STOP;
            r_timer_clr <= 1'b0;
            r_tick      <= 1'b0;
            r_tick_cnt  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_timer_clr <= w_clr_next;
            r_tick      <= w_tick_now;
            if (w_enter_play) begin
                r_tick_cnt <= '0;
            end else if (r_state == ST_PLAY) begin
                r_tick_cnt <= (r_tick_cnt == T_LAST) ? '0 : r_tick_cnt + 1'b1;
            end
        end
    end

    // Pressing both seek buttons at once cancels seeking and restarts the hold count.
    assign w_fwd_only  = w_fwd_lvl & ~w_back_lvl;
    assign w_back_only = w_back_lvl & ~w_fwd_lvl;
    assign w_hold_any  = w_fwd_only | w_back_only;
    assign w_seek_ok   = (r_state == ST_PLAY) || (r_state == ST_PAUSE);
    assign w_repeat    = w_hold_any && r_tick && (r_hold_cnt >= H_LAST);
    assign w_fire_fwd  = w_seek_ok && w_fwd_only && (w_fwd_press || w_repeat);
    assign w_fire_back = w_seek_ok && w_back_only && (w_back_press || w_repeat);
    assign w_fire      = w_fire_fwd | w_fire_back;

`ifdef SEEK_ACCEL_EN
    logic [3:0] r_rep_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rep_cnt <= 4'd0;
        end else if (!w_hold_any) begin
            r_rep_cnt <= 4'd0;
        end else if (w_repeat && (r_rep_cnt != 4'd8)) begin
            r_rep_cnt <= r_rep_cnt + 4'd1;
        end
    end

    always_comb begin
        w_base = STEP1;
        if (w_repeat) begin
            if (r_rep_cnt >= 4'd8)      w_base = STEP4;
            else if (r_rep_cnt >= 4'd4) w_base = STEP2;
        end
    end
`else
    assign w_base = STEP1;
`endif

    assign w_room     = w_past_end ? 10'd0 : (w_len10 - w_pos10);
    assign w_fwd_mag  = (w_base < w_room) ? w_base : w_room;
    assign w_back_mag = (w_base < w_pos10) ? w_base : w_pos10;
    assign w_mag      = w_fire_fwd ? w_fwd_mag : w_back_mag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seek_valid <= 1'b0;
            r_seek_step  <= '0;
            r_hold_cnt   <= '0;
            r_play_d     <= 1'b0;
            r_fwd_d      <= 1'b0;
            r_back_d     <= 1'b0;
        end else begin
            r_play_d     <= w_play_lvl;
            r_fwd_d      <= w_fwd_lvl;
            r_back_d     <= w_back_lvl;
            r_seek_valid <= w_fire && (w_mag != 10'd0);
            if (w_fire && (w_mag != 10'd0)) begin
                r_seek_step <= 9'(w_fire_fwd ? w_mag : (10'd0 - w_mag));
            end
            if (!w_hold_any) begin
                r_hold_cnt <= '0;
            end else if (r_tick && (r_hold_cnt != H_MAX)) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    assign o_count      = (r_state == ST_PLAY);
    assign o_at_end     = (r_state == ST_END);
    assign o_tick       = r_tick;
    assign o_timer_clr  = r_timer_clr;
    assign o_seek_valid = r_seek_valid;
    assign o_seek_step  = r_seek_step;
endmodule

// File: tb/tb_seek_controller.sv
// tb/tb_seek_controller.sv - directed table-driven bench for seek_controller
module tb_seek_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic       btn_play, btn_fwd, btn_back;
    logic [8:0] position, song_len;
    logic       count, tick, seek_valid, timer_clr, at_end;
    logic [8:0] seek_step;

    always #5 clk = ~clk;

    seek_controller #(.TICK_DIV(10), .DEBOUNCE_CYC(4), .HOLD_TICKS(2), .STEP(10)) dut (
        .clk(clk), .reset(reset),
        .i_btn_play(btn_play), .i_btn_fwd(btn_fwd), .i_btn_back(btn_back),
        .i_position(position), .i_song_len(song_len),
        .o_count(count), .o_tick(tick), .o_seek_step(seek_step),
        .o_seek_valid(seek_valid), .o_timer_clr(timer_clr), .o_at_end(at_end));

    typedef struct {
        logic       pause;
        logic       fwd;
        logic [8:0] pos;
        int         pulses;
        logic [8:0] step;
    } vec_t;

    vec_t       vt[10];
    int         total = 0;
    int         bad = 0;
    int         np;
    logic [8:0] st;
    logic       paused;
    logic       flag_a, flag_b;
    int         ns;
    int         cyc[8];
    logic [8:0] stp[8];
    int         exp_cyc[7];
    logic [8:0] exp_stp[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic seek_window(input logic fwd, input int hold, input int cycles,
                               output int pulses, output logic [8:0] last_step);
        pulses = 0;
        last_step = '0;
        if (fwd) btn_fwd = 1'b1;
        else     btn_back = 1'b1;
        for (int c = 1; c <= cycles; c++) begin
            @(negedge clk);
            if (seek_valid) begin
                pulses++;
                last_step = seek_step;
            end
            if (c == hold) begin
                btn_fwd = 1'b0;
                btn_back = 1'b0;
            end
        end
    endtask

    task automatic play_window(output int clr_pulses);
        clr_pulses = 0;
        btn_play = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (timer_clr) clr_pulses++;
            if (c == 8) btn_play = 1'b0;
        end
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        while (!tick && n < 25) begin
            @(negedge clk);
            n++;
        end
        check("tick_seen", tick, 1);
    endtask

    initial begin
        vt[0] = '{1'b0, 1'b1, 9'd50, 1, 9'd10};
        vt[1] = '{1'b0, 1'b0, 9'd50, 1, 9'h1F6};
        vt[2] = '{1'b1, 1'b1, 9'd95, 1, 9'd5};
        vt[3] = '{1'b1, 1'b0, 9'd3,  1, 9'h1FD};
        vt[4] = '{1'b1, 1'b0, 9'd0,  0, 9'h1FD};
        vt[5] = '{1'b1, 1'b1, 9'd90, 1, 9'd10};
        vt[6] = '{1'b1, 1'b1, 9'd91, 1, 9'd9};
        vt[7] = '{1'b1, 1'b0, 9'd10, 1, 9'h1F6};
        vt[8] = '{1'b1, 1'b0, 9'd9,  1, 9'h1F7};
        vt[9] = '{1'b1, 1'b1, 9'd99, 1, 9'd1};
        exp_cyc = '{7, 21, 31, 41, 51, 61, 71};
`ifdef SEEK_ACCEL_EN
        exp_stp = '{9'd10, 9'd10, 9'd10, 9'd10, 9'd10, 9'd20, 9'd20};
`else
        exp_stp = '{9'd10, 9'd10, 9'd10, 9'd10, 9'd10, 9'd10, 9'd10};
`endif

        reset = 1'b1;
        btn_play = 1'b0;
        btn_fwd = 1'b0;
        btn_back = 1'b0;
        position = 9'd0;
        song_len = 9'd100;
        repeat (3) @(negedge clk);
        check("rst_count", count, 0);
        check("rst_tick", tick, 0);
        check("rst_valid", seek_valid, 0);
        check("rst_clr", timer_clr, 0);
        check("rst_end", at_end, 0);
        check("rst_step", seek_step, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Play press latency, timer clear and tick cadence.
        btn_play = 1'b1;
        repeat (6) @(negedge clk);
        check("play_count_early", count, 0);
        @(negedge clk);
        check("play_count", count, 1);
        check("play_clr", timer_clr, 1);
        @(negedge clk);
        check("play_clr_once", timer_clr, 0);
        btn_play = 1'b0;
        repeat (8) @(negedge clk);
        check("tick_early", tick, 0);
        @(negedge clk);
        check("tick_first", tick, 1);
        @(negedge clk);
        check("tick_pulse", tick, 0);
        repeat (9) @(negedge clk);
        check("tick_second", tick, 1);

        paused = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (vt[i].pause != paused) begin
                btn_play = 1'b1;
                repeat (8) @(negedge clk);
                btn_play = 1'b0;
                repeat (10) @(negedge clk);
                paused = vt[i].pause;
            end
            position = vt[i].pos;
            @(negedge clk);
            seek_window(vt[i].fwd, 7, 16, np, st);
            check($sformatf("vec%0d_pulses", i), np, vt[i].pulses);
            check($sformatf("vec%0d_step", i), seek_step, vt[i].step);
            check($sformatf("vec%0d_count", i), count, {31'd0, !vt[i].pause});
            repeat (2) @(negedge clk);
        end

        // Position beyond the song end in PAUSE.
        position = 9'd100;
        @(negedge clk);
        check("end_after_seek", at_end, 1);
        check("end_count", count, 0);
        position = 9'd50;
        seek_window(1'b1, 7, 16, np, st);
        check("end_no_seek", np, 0);
        check("end_step_held", seek_step, 1);
        position = 9'd0;
        play_window(np);
        check("end_play_clr", np, 1);
        check("end_play_count", count, 1);

        // Tick on the last second ends the song.
        position = 9'd99;
        wait_tick();
        @(negedge clk);
        check("tick_end", at_end, 1);
        check("tick_end_count", count, 0);
        position = 9'd0;
        play_window(np);
        check("replay_clr", np, 1);

        // Held forward: press seek, then one repeat per tick from the second tick.
        wait_tick();
        btn_fwd = 1'b1;
        ns = 0;
        for (int c = 1; c <= 90; c++) begin
            @(negedge clk);
            if (c == 72) btn_fwd = 1'b0;
            if (seek_valid) begin
                if (ns < 8) begin
                    cyc[ns] = c;
                    stp[ns] = seek_step;
                end
                ns++;
            end
        end
        check("hold_seeks", ns, 7);
        for (int k = 0; k < 7; k++) begin
            check($sformatf("hold%0d_cycle", k), cyc[k], exp_cyc[k]);
            check($sformatf("hold%0d_step", k), stp[k], exp_stp[k]);
        end
        check("hold_count", count, 1);

        // Both seek buttons held: nothing fires.
        btn_fwd = 1'b1;
        btn_back = 1'b1;
        ns = 0;
        repeat (35) begin
            @(negedge clk);
            if (seek_valid) ns++;
        end
        check("both_no_seek", ns, 0);
        btn_fwd = 1'b0;
        btn_back = 1'b0;
        repeat (12) @(negedge clk);

        // Reset during a pending seek, with buttons held across release.
        btn_fwd = 1'b1;
        btn_play = 1'b1;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_valid", seek_valid, 0);
        check("midrst_count", count, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        flag_a = 1'b0;
        flag_b = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (seek_valid) flag_a = 1'b1;
            if (count) flag_b = 1'b1;
        end
        check("held_no_seek", flag_a, 0);
        check("held_no_play", flag_b, 0);
        btn_fwd = 1'b0;
        btn_play = 1'b0;
        repeat (12) @(negedge clk);
        btn_play = 1'b1;
        repeat (6) @(negedge clk);
        check("repress_early", count, 0);
        @(negedge clk);
        check("repress_count", count, 1);
        btn_play = 1'b0;
        repeat (12) @(negedge clk);

        // Bounce on play: one press, seven samples after the last rising drive.
        flag_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            btn_play = (i % 2 == 0);
            repeat (2) begin
                @(negedge clk);
                if (!count) flag_a = 1'b0;
            end
        end
        btn_play = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (!count) flag_a = 1'b0;
        end
        check("bounce_no_press", flag_a, 1);
        @(negedge clk);
        check("bounce_press", count, 0);
        repeat (10) @(negedge clk);
        check("bounce_single", count, 0);
        btn_play = 1'b0;
        repeat (10) @(negedge clk);

        // Unloading the song forces STOP; play needs a song.
        song_len = 9'd0;
        @(negedge clk);
        check("nosong_count", count, 0);
        check("nosong_end", at_end, 0);
        play_window(np);
        check("nosong_clr", np, 0);
        check("nosong_stay", count, 0);
        song_len = 9'd100;
        @(negedge clk);
        play_window(np);
        check("stop_play_clr", np, 1);
        check("stop_play_count", count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seek_controller.md
# seek_controller

Playback transport and seek controller for the music player: it turns the front-panel play, forward and back buttons into the control inputs of the elapsed-time timer. Outputs are the count enable, a 1 Hz tick, a signed seek step with a valid strobe, and a timer clear. It also reads back the timer's current position, so seeks never go past the song bounds, and it detects end-of-song.

## Interface
- TICK_DIV, 50_000_000, clk cycles per 1 s tick
- DEBOUNCE_CYC, 500_000, cycles a synchronized button must be stable before its debounced level changes
- HOLD_TICKS, 2, ticks a seek button must be held before auto-repeat starts
- STEP, 10, seconds per seek step (1..63)
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- btn_play  in  1  raw play/pause button, active-high, asynchronous to clk
- btn_fwd  in  1  raw forward button, active-high
- btn_back  in  1  raw back button, active-high
- position  in  9  current elapsed seconds from the timer, unsigned
- song_len  in  9  song length in seconds, unsigned; 0 means no song loaded
- count  out  1  timer count enable; high only in PLAY
- tick  out  1  one-cycle pulse every TICK_DIV cycles while in PLAY
- seek_step  out  9  signed step in two's complement; holds its last value between strobes
- seek_valid  out  1  one-cycle strobe; timer adds seek_step when it is high
- timer_clr  out  1  one-cycle strobe; zeroes the timer
- at_end  out  1  high in END state

## Operation
- Each button path: 2-FF synchronizer, then a debouncer.
  - Debounced level changes after DEBOUNCE_CYC consecutive cycles of a stable synchronized value.
  - A press event is the rising edge of the debounced level.
- States: STOP, PLAY, PAUSE, END. Transitions:
  - STOP, play press, song_len != 0: go to PLAY and pulse timer_clr.
  - PLAY, play press: go to PAUSE.
  - PAUSE, play press: go to PLAY.
  - END, play press: go to PLAY and pulse timer_clr.
  - PLAY, tick while position >= song_len - 1: go to END.
  - PLAY or PAUSE, position >= song_len (for example after a seek): go to END on the next cycle.
  - Any state, song_len == 0: go to STOP.
- Seeks are accepted in PLAY and PAUSE only; they are ignored in STOP and END.
  - A seek fires on a press event, and on every tick while the button stays held after HOLD_TICKS ticks (auto-repeat).
  - Fwd and back both debounced-high: no seeks and no repeat. The hold counter clears.
- Seek step arithmetic is done in 10 bits and the result is truncated to 9 bits signed.
  - Forward: step = min(STEP, song_len - position).
  - Back: step = -min(STEP, position).
  - If the clamped step is 0, seek_valid stays low.
- The tick counter clears on every entry into PLAY and holds its value in other states.
- A seek strobe and a tick may occur in the same cycle; both are issued. The timer sums them.

## Timing
- Reset values:
  - count = 0, tick = 0, seek_valid = 0, timer_clr = 0, at_end = 0.
  - seek_step = 0, state = STOP.
  - All debouncers and counters are cleared to 0.
- Button to press event:
  - 2 synchronizer cycles plus DEBOUNCE_CYC cycles.
  - The state change or seek_valid appears on the cycle after the press event.
- All outputs are registered. count follows the state register with no extra delay.
- First tick after entering PLAY occurs TICK_DIV cycles after the entry cycle; ticks then repeat every TICK_DIV cycles.
- Reset asserted mid-seek: any pending strobe is dropped and no strobe is issued after reset releases.
- A button held across reset release produces no press event until it is released and pressed again.

## Configuration
- SEEK_ACCEL_EN defined:
  - After 4 consecutive auto-repeats, the repeat step doubles to 2*STEP.
  - After 8 consecutive auto-repeats, it becomes 4*STEP, capped at 255 before clamping.
  - Releasing the button returns the step to STEP.
- SEEK_ACCEL_EN undefined: every seek uses STEP and no acceleration logic is built.

## Test plan
All scenarios use TICK_DIV=10, DEBOUNCE_CYC=4, HOLD_TICKS=2, STEP=10, song_len=100.
- Reset, then press play -> timer_clr pulses once; count=1 in the cycle after the press event; tick pulses every 10 cycles.
- Play at position=50, press fwd once -> one seek_valid with seek_step=+10; count stays 1.
- PAUSE at position=95, press fwd -> seek_step=+5. The next cycle with position=100 -> END, at_end=1, count=0.
- Position=3, press back -> seek_step=-3. Position=0, press back -> no seek_valid.
- Button bounce toggling every 2 cycles for 20 cycles, then held high -> exactly one press event, 6 cycles after it stabilises.
- Hold fwd in PLAY at position=0 -> seek at the press event, then one seek per tick starting on the 2nd tick. With SEEK_ACCEL_EN, the 5th repeat has seek_step=+20.
